// File: rtl/spi_vip_master_arbiter.sv
// SPI master engine shared round-robin between NUM_REQ word requesters.
// Each grant serializes one word MSB first and returns the captured MISO word with the requester id.
module spi_vip_master_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_DLENGTH = 16,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0,
  parameter bit INV_CS       = 1'b0,
  parameter int CLK_DIV      = 1
) (
  input  logic                                            clk,
  input  logic                                            resetn,
  input  logic [NUM_REQ-1:0]                              req_valid,
  output logic [NUM_REQ-1:0]                              req_ready,
  input  logic [NUM_REQ*DATA_DLENGTH-1:0]                 req_data,
  output logic                                            rsp_valid,
  input  logic                                            rsp_ready,
  output logic [DATA_DLENGTH-1:0]                         rsp_data,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic                                            spi_sclk,
  output logic                                            spi_mosi,
  input  logic                                            spi_miso,
  output logic                                            spi_cs
);

  localparam int DW  = DATA_DLENGTH;
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ECW = $clog2(2 * DW + 1);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DW - 1);
  localparam logic [7:0]     DIV_END   = 8'(CLK_DIV);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  // Handshakes: a requester word moves when req_valid[i] && req_ready[i] on a rising clk edge;
  // the response moves when rsp_valid && rsp_ready. req_ready is only ever raised in IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     div_q, div_d;
  logic [ECW-1:0] edge_q, edge_d;
  logic [DW-1:0]  tx_q, tx_d;
  logic [DW-1:0]  rx_q, rx_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [DW-1:0]  grant_data;
  logic           div_end;
  logic           sample_edge;
  logic           cs_on;

  // Scan from the round-robin pointer, wrapping, and take the first pending requester.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
    grant_data = req_data[int'(grant_idx)*DW +: DW];
  end

  assign div_end     = (div_q == DIV_END);
  // Edge numbering starts at 1, so an even edge_q means the next edge is a leading one.
  assign sample_edge = (edge_q[0] == CPHA);

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          id_d      = grant_idx;
          ptr_d     = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
          rx_d      = '0;
          if (!CPHA) begin
            mosi_d = grant_data[DW-1];
            tx_d   = grant_data << 1;
          end else begin
            tx_d   = grant_data;
          end
          state_d = S_SETUP;
        end
      end
      S_SETUP: if (div_end) state_d = S_SHIFT;
      S_SHIFT: begin
        if (div_end) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + ECW'(1);
          if (sample_edge) begin
            rx_d = DW'({rx_q, spi_miso});
          end else begin
            mosi_d = tx_q[DW-1];
            tx_d   = tx_q << 1;
          end
          if (edge_q == LAST_EDGE) state_d = S_HOLD;
        end
      end
      S_HOLD:  if (div_end) state_d = S_GAP;
      S_GAP:   if (div_end) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The divider only runs in the timed states; both counters restart on every state change.
    div_d = ((state_q inside {S_SETUP, S_SHIFT, S_HOLD, S_GAP}) && !div_end) ? div_q + 8'd1 : 8'd0;
    if (state_d != state_q) begin
      div_d  = 8'd0;
      edge_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  // Gating with resetn drops chip select in the same instant reset asserts.
  assign cs_on     = resetn && (state_q inside {S_SETUP, S_SHIFT, S_HOLD});
  assign spi_cs    = cs_on ? INV_CS : !INV_CS;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rx_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_spi_vip_master_arbiter.sv
// Directed bench for spi_vip_master_arbiter: mode-0 loopback, mode-3 slave model,
// round-robin order, response backpressure, mid-transfer reset and inverted chip select.
module tb_spi_vip_master_arbiter;

  localparam int CLK_P = 10;

  logic clk = 1'b0;
  logic resetn;
  always #(CLK_P/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (mode 0, H=2), MISO looped back from MOSI
  logic [1:0]  req_valid_a, req_ready_a;
  logic [31:0] req_data_a;
  logic        rsp_valid_a, rsp_ready_a;
  logic [15:0] rsp_data_a;
  logic [0:0]  rsp_id_a;
  logic        sclk_a, mosi_a, cs_a;
  wire         miso_a = mosi_a;

  spi_vip_master_arbiter u_dut_a (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_data(req_data_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a), .rsp_id(rsp_id_a),
    .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .spi_cs(cs_a)
  );

  // Instance B: CPOL=1 CPHA=1 against a small slave model returning 0xCAFE
  logic [1:0]  req_valid_b, req_ready_b;
  logic [31:0] req_data_b;
  logic        rsp_valid_b, rsp_ready_b;
  logic [15:0] rsp_data_b;
  logic [0:0]  rsp_id_b;
  logic        sclk_b, mosi_b, cs_b, miso_b;

  spi_vip_master_arbiter #(.CPOL(1'b1), .CPHA(1'b1)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_data(req_data_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_id(rsp_id_b),
    .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b), .spi_cs(cs_b)
  );

  // Instance C: active-high chip select, H=1, loopback
  logic [1:0]  req_valid_c, req_ready_c;
  logic [31:0] req_data_c;
  logic        rsp_valid_c, rsp_ready_c;
  logic [15:0] rsp_data_c;
  logic [0:0]  rsp_id_c;
  logic        sclk_c, mosi_c, cs_c;
  wire         miso_c = mosi_c;

  spi_vip_master_arbiter #(.INV_CS(1'b1), .CLK_DIV(0)) u_dut_c (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid_c), .req_ready(req_ready_c), .req_data(req_data_c),
    .rsp_valid(rsp_valid_c), .rsp_ready(rsp_ready_c), .rsp_data(rsp_data_c), .rsp_id(rsp_id_c),
    .spi_sclk(sclk_c), .spi_mosi(mosi_c), .spi_miso(miso_c), .spi_cs(cs_c)
  );

  // Mode-3 slave: drives MISO on the falling (leading) edge, samples MOSI on the rising edge.
  logic [15:0] slv_tx  = 16'hCAFE;
  logic [15:0] slv_rx  = 16'h0000;
  logic        slv_out = 1'b0;
  assign miso_b = slv_out;

  always @(negedge sclk_b or posedge cs_b) begin
    if (cs_b) begin
      slv_tx  <= 16'hCAFE;
      slv_out <= 1'b0;
    end else begin
      slv_out <= slv_tx[15];
      slv_tx  <= {slv_tx[14:0], 1'b0};
    end
  end

  always @(posedge sclk_b) begin
    if (!cs_b) slv_rx <= {slv_rx[14:0], mosi_b};
  end

  // sclk rising-edge counters and period timestamps
  int  rises_a = 0, rises_c = 0;
  time tp_a = 0, tl_a = 0, tp_c = 0, tl_c = 0;
  always @(posedge sclk_a) begin
    rises_a <= rises_a + 1;
    tp_a    <= tl_a;
    tl_a    <= $time;
  end
  always @(posedge sclk_c) begin
    rises_c <= rises_c + 1;
    tp_c    <= tl_c;
    tl_c    <= $time;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int base;
    int seen;

    // ---------------- reset state ----------------
    resetn      = 1'b0;
    req_valid_a = '0; req_data_a = '0; rsp_ready_a = 1'b1;
    req_valid_b = '0; req_data_b = '0; rsp_ready_b = 1'b1;
    req_valid_c = '0; req_data_c = '0; rsp_ready_c = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid_a, 1'b0);
    check("rst_req_ready", req_ready_a, 2'b00);
    check("rst_rsp_data",  rsp_data_a, 16'h0000);
    check("rst_rsp_id",    rsp_id_a, 1'b0);
    check("rst_sclk_a",    sclk_a, 1'b0);
    check("rst_mosi_a",    mosi_a, 1'b0);
    check("rst_cs_a",      cs_a, 1'b1);
    check("rst_sclk_b",    sclk_b, 1'b1);
    check("rst_cs_b",      cs_b, 1'b1);
    check("rst_cs_c",      cs_c, 1'b0);
    check("rst_sclk_c",    sclk_c, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // ---------------- T1: mode 0 loopback, latency, sclk period ----------------
    req_data_a  = {16'h0000, 16'hA5C3};
    req_valid_a = 2'b01;
    #1;
    check("t1_grant", req_ready_a, 2'b01);
    base = rises_a;
    @(negedge clk);
    req_valid_a = 2'b00;
    n = 1;
    while (!rsp_valid_a && n < 300) begin
      if (n == 20) check("t1_cs_active", cs_a, 1'b0);
      @(negedge clk);
      n++;
    end
    check("t1_latency",   n, 71);
    check("t1_rsp_data",  rsp_data_a, 16'hA5C3);
    check("t1_rsp_id",    rsp_id_a, 1'b0);
    check("t1_sclk_rises", rises_a - base, 16);
    check("t1_sclk_period", tl_a - tp_a, 4 * CLK_P);
    check("t1_cs_idle",   cs_a, 1'b1);
    check("t1_sclk_idle", sclk_a, 1'b0);

    // ---------------- T2: response backpressure ----------------
    @(negedge clk);
    rsp_ready_a = 1'b0;
    req_data_a  = {16'h3C5A, 16'h0F0F};
    req_valid_a = 2'b10;
    #1;
    check("t2_grant", req_ready_a, 2'b10);
    @(negedge clk);
    req_valid_a = 2'b00;
    n = 1;
    while (!rsp_valid_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t2_latency", n, 71);
    req_valid_a = 2'b01;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("t2_stall", {rsp_valid_a, rsp_data_a, rsp_id_a, cs_a, req_ready_a},
            {1'b1, 16'h3C5A, 1'b1, 1'b1, 2'b00});
      @(negedge clk);
    end
    rsp_ready_a = 1'b1;
    #1;
    check("t2_no_grant_in_resp", req_ready_a, 2'b00);

    // ---------------- T3: reset at SHIFT edge 9 ----------------
    @(negedge clk);
    #1;
    check("t3_grant", req_ready_a, 2'b01);
    base = rises_a;
    @(negedge clk);
    req_valid_a = 2'b00;
    n = 0;
    while ((rises_a - base) < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_edges_before_reset", rises_a - base, 5);
    check("t3_cs_before_reset", cs_a, 1'b0);
    resetn = 1'b0;
    #1;
    check("t3_cs_reset",   cs_a, 1'b1);
    check("t3_sclk_reset", sclk_a, 1'b0);
    check("t3_mosi_reset", mosi_a, 1'b0);
    check("t3_rsp_data_reset", rsp_data_a, 16'h0000);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid_a) seen++;
    end
    check("t3_no_stale_rsp", seen, 0);

    // ---------------- T4: round-robin order with both requesting ----------------
    req_data_a  = {16'hBEEF, 16'h1357};
    req_valid_a = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (req_ready_a == 2'b00 && n < 300) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("t4_grant", req_ready_a, (k % 2 == 1) ? 2'b10 : 2'b01);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid_a && n < 300);
      check("t4_rsp_id",   rsp_id_a, (k % 2 == 1) ? 1'b1 : 1'b0);
      check("t4_rsp_data", rsp_data_a, (k % 2 == 1) ? 16'hBEEF : 16'h1357);
      if (k == 3) req_valid_a = 2'b00;
    end
    @(negedge clk);

    // ---------------- T5: CPOL=1 CPHA=1 against slave model ----------------
    req_data_b  = {16'h0000, 16'h6E91};
    req_valid_b = 2'b01;
    #1;
    check("t5_grant", req_ready_b, 2'b01);
    @(negedge clk);
    req_valid_b = 2'b00;
    n = 1;
    while (!rsp_valid_b && n < 300) begin
      if (n == 30) check("t5_cs_active", cs_b, 1'b0);
      @(negedge clk);
      n++;
    end
    check("t5_latency",   n, 71);
    check("t5_rsp_data",  rsp_data_b, 16'hCAFE);
    check("t5_rsp_id",    rsp_id_b, 1'b0);
    check("t5_slave_rx",  slv_rx, 16'h6E91);
    check("t5_sclk_idle", sclk_b, 1'b1);
    check("t5_cs_idle",   cs_b, 1'b1);
    @(negedge clk);

    // ---------------- T6: active-high cs, H=1, requester 1 ----------------
    req_data_c  = {16'h0001, 16'h0000};
    req_valid_c = 2'b10;
    #1;
    check("t6_grant", req_ready_c, 2'b10);
    base = rises_c;
    @(negedge clk);
    req_valid_c = 2'b00;
    n = 1;
    while (!rsp_valid_c && n < 300) begin
      if (n == 5) check("t6_cs_active", cs_c, 1'b1);
      @(negedge clk);
      n++;
    end
    check("t6_latency",     n, 36);
    check("t6_rsp_data",    rsp_data_c, 16'h0001);
    check("t6_rsp_id",      rsp_id_c, 1'b1);
    check("t6_sclk_rises",  rises_c - base, 16);
    check("t6_sclk_period", tl_c - tp_c, 2 * CLK_P);
    check("t6_cs_idle",     cs_c, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
